button_link_tx: RTL

- Slave-side serializer for the two-board controller link: carries the slave's five raw player-2 buttons to the master board over one PMOD wire.
- Replaces the five parallel level wires. The master-side deserializer reconstructs the button levels and feeds slaveMasterSetter.
- Sends a frame whenever the synchronized button vector changes, and also on a periodic refresh so the master can detect a dead link.
- Runs on the 100 MHz board clock.

---
 rtl/button_link_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/button_link_tx.sv
// Slave-side serializer: five synchronized button levels go out as start/payload/parity/stop frames
// on one idle-high wire. Define BUTTON_LINK_TWO_STOP_EN for an 11-bit frame with a second stop bit.
module button_link_tx #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int REFRESH_CYCLES = 2500000,
    parameter int GAP_BITS       = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] btn_in,
    output logic       tx_out,
    output logic       busy,
    output logic [1:0] seq,
    output logic [7:0] frame_count
);
`ifdef BUTTON_LINK_TWO_STOP_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int CYC_W      = $clog2(CLKS_PER_BIT);
    localparam int GAP_W      = $clog2(GAP_CYCLES);
    localparam int REF_W      = $clog2(REFRESH_CYCLES);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t state_reg, state_next;

    logic [4:0]            btn_meta_reg, btn_sync_reg, last_sent_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [CYC_W-1:0]      cycle_cnt_reg;
    logic [3:0]            bit_cnt_reg;
    logic [GAP_W-1:0]      gap_cnt_reg;
    logic [REF_W-1:0]      refresh_cnt_reg;
    logic [1:0]            seq_reg;
    logic [7:0]            frame_count_reg;
    logic                  tx_out_reg, busy_reg;
    logic                  tx_out_next, busy_next;

    logic                  refresh_due, trigger, bit_done, last_bit, gap_done;
    logic [1:0]            seq_inc;
    logic [FRAME_BITS-1:0] frame_load;

    assign refresh_due = (refresh_cnt_reg == REF_W'(REFRESH_CYCLES - 1));
    assign trigger     = (state_reg == IDLE) && enable &&
                         ((btn_sync_reg != last_sent_reg) || refresh_due);
    assign bit_done    = (cycle_cnt_reg == CYC_W'(CLKS_PER_BIT - 1));
    assign last_bit    = (bit_cnt_reg == 4'(FRAME_BITS - 1));
    assign gap_done    = (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1));
    assign seq_inc     = seq_reg + 2'd1;
    // Shifted out LSB first: start, buttons, seq, even parity, then one or two stop bits.
    assign frame_load  = {{(FRAME_BITS - 9){1'b1}}, ^{seq_inc, btn_sync_reg},
                          seq_inc, btn_sync_reg, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger) state_next = SHIFT;
            SHIFT:   if (bit_done && last_bit) state_next = GAP;
            GAP:     if (gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed for the coming cycle so tx_out and busy leave flops directly.
    always_comb begin
        tx_out_next = 1'b1;
        busy_next   = (state_next != IDLE);
        if (state_next == SHIFT) begin
            if (state_reg == IDLE) tx_out_next = 1'b0;
            else if (bit_done)     tx_out_next = shift_reg[1];
            else                   tx_out_next = shift_reg[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_reg    <= '0;
            btn_sync_reg    <= '0;
            last_sent_reg   <= '0;
            shift_reg       <= '1;
            cycle_cnt_reg   <= '0;
            bit_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            refresh_cnt_reg <= '0;
            seq_reg         <= '0;
            frame_count_reg <= '0;
            tx_out_reg      <= 1'b1;
            busy_reg        <= 1'b0;
        end else begin
            btn_meta_reg <= btn_in;
            btn_sync_reg <= btn_meta_reg;
            tx_out_reg   <= tx_out_next;
            busy_reg     <= busy_next;

            if (trigger || !enable)  refresh_cnt_reg <= '0;
            else if (!refresh_due)   refresh_cnt_reg <= refresh_cnt_reg + REF_W'(1);

            gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + GAP_W'(1) : '0;

            case (state_reg)
                IDLE: begin
                    cycle_cnt_reg <= '0;
                    bit_cnt_reg   <= '0;
                    if (trigger) begin
                        shift_reg       <= frame_load;
                        last_sent_reg   <= btn_sync_reg;
                        seq_reg         <= seq_inc;
                        frame_count_reg <= frame_count_reg + 8'd1;
                    end
                end
                SHIFT: begin
                    if (bit_done) begin
                        cycle_cnt_reg <= '0;
                        shift_reg     <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                        bit_cnt_reg   <= bit_cnt_reg + 4'd1;
                    end else begin
                        cycle_cnt_reg <= cycle_cnt_reg + CYC_W'(1);
                    end
                end
                default: begin
                    cycle_cnt_reg <= '0;
                    bit_cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign tx_out      = tx_out_reg;
    assign busy        = busy_reg;
    assign seq         = seq_reg;
    assign frame_count = frame_count_reg;

endmodule
